// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the data-memory responder
package mips_mem_pkg;

  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int WORD_OFF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmr_state_t;

endpackage

// File: rtl/dmr_ram.sv
// rtl/dmr_ram.sv - single-port word RAM with byte write enables and registered read
module dmr_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are deliberately unreset; a read only updates the output register on a load.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - handshaked data-memory responder with wait states; optional DMR_ALIGN_CHECK_EN rejects misaligned requests
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk_DMR,
  input  logic        rstn_DMR,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  dmr_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              err_q, err_d;

  logic              accept;
  logic [ADDR_W-1:0] req_idx;
  logic              req_misalign;
  logic              unused_addr_bits;

  logic              acc_go;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_err;
  logic [DATA_W-1:0] ram_rdata;

  assign req_ready        = rstn_DMR & (state_q == IDLE);
  assign accept           = req_valid & req_ready;
  assign req_idx          = req_addr[ADDR_W+WORD_OFF-1:WORD_OFF];
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+WORD_OFF], req_addr[WORD_OFF-1:0]};

`ifdef DMR_ALIGN_CHECK_EN
  assign req_misalign = |req_addr[WORD_OFF-1:0];
`else
  assign req_misalign = 1'b0;
`endif

  // FSM, wait counter and request latch next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = req_misalign;
          if (WS == 4'd0) begin
            state_d = RESP;
          end else begin
            cnt_d   = WS - 4'd1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight request.
  always_ff @(posedge clk_DMR or negedge rstn_DMR) begin
    if (!rstn_DMR) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  // The array is touched only on the edge that enters RESP; with zero wait states that
  // is the accept edge itself, so the live request bypasses the latch.
  always_comb begin
    acc_go    = ((state_q == IDLE) && accept && (WS == 4'd0)) ||
                ((state_q == WAIT) && (cnt_q == 4'd0));
    acc_wr    = (state_q == IDLE) ? req_write    : wr_q;
    acc_idx   = (state_q == IDLE) ? req_idx      : idx_q;
    acc_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;
    acc_be    = (state_q == IDLE) ? req_be       : be_q;
    acc_err   = (state_q == IDLE) ? req_misalign : err_q;
  end

  dmr_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_DMR),
    .en    (acc_go & ~acc_err),
    .we    (acc_wr),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (ram_rdata)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = (rsp_valid && !wr_q && !err_q) ? ram_rdata : '0;

`ifdef DMR_ALIGN_CHECK_EN
  assign rsp_err = rsp_valid & err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk;
  logic        rstn;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] rsp_rdata1;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(2)) dut0 (
    .clk_DMR   (clk),
    .rstn_DMR  (rstn),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid0),
    .rsp_ready (rsp_ready0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0)
  );

  data_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(0)) dut1 (
    .clk_DMR   (clk),
    .rstn_DMR  (rstn),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid1),
    .rsp_ready (rsp_ready1),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic g_rv(input int d);
    return (d == 0) ? rsp_valid0 : rsp_valid1;
  endfunction
  function automatic logic g_rr(input int d);
    return (d == 0) ? req_ready0 : req_ready1;
  endfunction
  function automatic logic [31:0] g_rd(input int d);
    return (d == 0) ? rsp_rdata0 : rsp_rdata1;
  endfunction
  function automatic logic g_er(input int d);
    return (d == 0) ? rsp_err0 : rsp_err1;
  endfunction

  // One request on DUT d: latency counted in edges including the accept edge,
  // then hold cycles of backpressure, then the response handshake.
  task automatic xact(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int n;
    int exp_lat;
    exp_lat = (d == 0) ? 3 : 1;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    if (d == 0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
    end while (!g_rv(d) && n < 20);
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " rdata"}, g_rd(d), exp_rdata);
    chk({tag, " err"}, {31'b0, g_er(d)}, {31'b0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " bp rsp_valid"}, {31'b0, g_rv(d)}, 32'd1);
      chk({tag, " bp rdata"}, g_rd(d), exp_rdata);
      chk({tag, " bp req_ready"}, {31'b0, g_rr(d)}, 32'd0);
    end
    @(negedge clk);
    if (d == 0) rsp_ready0 = 1'b1; else rsp_ready1 = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready0 = 1'b0;
    rsp_ready1 = 1'b0;
    chk({tag, " idle req_ready"}, {31'b0, g_rr(d)}, 32'd1);
    chk({tag, " idle rsp_valid"}, {31'b0, g_rv(d)}, 32'd0);
  endtask

  initial begin
    int n;
    rstn       = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    rsp_ready0 = 1'b0;
    rsp_ready1 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", {31'b0, req_ready0}, 32'd0);
    chk("reset rsp_valid", {31'b0, rsp_valid0}, 32'd0);
    chk("reset rdata", rsp_rdata0, 32'd0);
    chk("reset err", {31'b0, rsp_err0}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post-reset req_ready0", {31'b0, req_ready0}, 32'd1);
    chk("post-reset req_ready1", {31'b0, req_ready1}, 32'd1);

    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, "store full");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, "load full");
    xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 32'h0, 1'b0, "store be0101");
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, 32'hDE22BE44, 1'b0, "load backpressure");
    xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0, "store be0");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDE22BE44, 1'b0, "load after be0");
    xact(0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0, "store wrap");
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0, "load wrap");
    xact(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 0, 32'h0, 1'b0, "ws0 store");
    xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 2, 32'h12345678, 1'b0, "ws0 load");

`ifdef DMR_ALIGN_CHECK_EN
    xact(0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1, "misaligned store");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDE22BE44, 1'b0, "load after misaligned");
`else
    xact(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, 32'hDE22BE44, 1'b0, "offset ignored load");
`endif

    // Reset while a response is being presented.
    @(negedge clk);
    req_write  = 1'b0;
    req_addr   = 32'h10;
    req_valid0 = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      req_valid0 = 1'b0;
    end while (!rsp_valid0 && n < 20);
    chk("midop rsp_valid before reset", {31'b0, rsp_valid0}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("midop rsp_valid dropped", {31'b0, rsp_valid0}, 32'd0);
    chk("midop req_ready in reset", {31'b0, req_ready0}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("midop req_ready after release", {31'b0, req_ready0}, 32'd1);

    // Store interrupted by reset during its wait states must not land.
    @(negedge clk);
    req_write  = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'h00000000;
    req_be     = 4'hF;
    req_valid0 = 1'b1;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("discard rsp_valid", {31'b0, rsp_valid0}, 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDE22BE44, 1'b0, "load after discarded store");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
